pong_match_ctrl: RTL and testbench

Match-level controller for the pong core: sits downstream of the ball/paddle engine and upstream of the score and text renderers. It consumes per-point edge events, the per-frame `animate` tick and the debounced control pulse. It owns the scores, serve direction, point hold-off timing, win detection and game-over blink, and tells the engine when it may animate.

---
 rtl/pong_match_ctrl_if.sv | 32 +++
 rtl/pong_match_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_pong_match_ctrl.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/pong_match_ctrl_if.sv
// pong_match_ctrl_if: groups the match-controller signals.
// The master side is the engine/input logic.
// The slave side is the match controller itself.
interface pong_match_ctrl_if #(
   parameter int SCORE_W = 4
);
   logic               frame;
   logic               sig_ctrl;
   logic               pt_p1;
   logic               pt_p2;
   logic [SCORE_W-1:0] score_p1;
   logic [SCORE_W-1:0] score_p2;
   logic [2:0]         phase;
   logic               rally;
   logic               serve_start;
   logic               serve_dir;
   logic [1:0]         winner;
   logic               game_over;
   logic               blink;

   modport master (
      output frame, sig_ctrl, pt_p1, pt_p2,
      input  score_p1, score_p2, phase, rally, serve_start, serve_dir,
             winner, game_over, blink
   );

   modport slave (
      input  frame, sig_ctrl, pt_p1, pt_p2,
      output score_p1, score_p2, phase, rally, serve_start, serve_dir,
             winner, game_over, blink
   );
endinterface

// File: rtl/pong_match_ctrl.sv
// pong_match_ctrl: match-level controller for the pong core.
// Owns the scores, serve direction, point hold-off, win detection and game-over blink.
// Optional macro PONG_WIN_BY_TWO_EN: a win needs a two-point lead, and a tie at or above
// WIN_SCORE drops back to deuce.
module pong_match_ctrl #(
   parameter int WIN_SCORE    = 10,
   parameter int SCORE_W      = 4,
   parameter int HOLD_FRAMES  = 120,
   parameter int BLINK_FRAMES = 16
) (
   input logic                  clk_pix,
   input logic                  rst,
   pong_match_ctrl_if.slave     bus
);
   localparam int HOLD_W  = (HOLD_FRAMES  > 1) ? $clog2(HOLD_FRAMES)  : 1;
   localparam int BLINK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
   localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(HOLD_FRAMES - 1);
   localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_FRAMES - 1);
   localparam logic [SCORE_W:0]   WIN_EXT    = (SCORE_W+1)'(WIN_SCORE);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      SERVE = 3'd1,
      RALLY = 3'd2,
      POINT = 3'd3,
      OVER  = 3'd4
   } state_t;

   state_t              state_q, state_d;
   logic [SCORE_W-1:0]  score_p1_q, score_p1_d;
   logic [SCORE_W-1:0]  score_p2_q, score_p2_d;
   logic                serve_dir_q, serve_dir_d;
   logic [1:0]          winner_q, winner_d;
   logic                blink_q, blink_d;
   logic                rally_q, game_over_q, serve_start_q;
   logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
   logic [BLINK_W-1:0]  blink_cnt_q, blink_cnt_d;

   // Candidate scores after a single point, plus the win decision on them.
   logic [SCORE_W-1:0]  n1, n2;
   logic                p1_win, p2_win;

   // State and output registers; reset drops everything to IDLE / zero at once.
   always_ff @(posedge clk_pix or posedge rst) begin
      if (rst) begin
         state_q       <= IDLE;
         score_p1_q    <= '0;
         score_p2_q    <= '0;
         serve_dir_q   <= 1'b0;
         winner_q      <= 2'b00;
         blink_q       <= 1'b0;
         rally_q       <= 1'b0;
         game_over_q   <= 1'b0;
         serve_start_q <= 1'b0;
         hold_cnt_q    <= '0;
         blink_cnt_q   <= '0;
      end else begin
         state_q       <= state_d;
         score_p1_q    <= score_p1_d;
         score_p2_q    <= score_p2_d;
         serve_dir_q   <= serve_dir_d;
         winner_q      <= winner_d;
         blink_q       <= blink_d;
         rally_q       <= (state_d == RALLY);
         game_over_q   <= (state_d == OVER);
         serve_start_q <= (state_d == SERVE) && (state_q != SERVE);
         hold_cnt_q    <= hold_cnt_d;
         blink_cnt_q   <= blink_cnt_d;
      end
   end

   // Next-state, scoring, win detection and the hold/blink frame counters.
   always_comb begin
      state_d     = state_q;
      score_p1_d  = score_p1_q;
      score_p2_d  = score_p2_q;
      serve_dir_d = serve_dir_q;
      winner_d    = winner_q;
      blink_d     = blink_q;
      hold_cnt_d  = hold_cnt_q;
      blink_cnt_d = blink_cnt_q;
      n1          = score_p1_q;
      n2          = score_p2_q;
      p1_win      = 1'b0;
      p2_win      = 1'b0;

      case (state_q)
         IDLE: begin
            if (bus.sig_ctrl) state_d = SERVE;
         end
         SERVE: begin
            if (bus.sig_ctrl) state_d = RALLY;
         end
         RALLY: begin
            if (bus.pt_p1 && bus.pt_p2) begin
               // Simultaneous edge events are treated as a replay.
               state_d = POINT;
            end else if (bus.pt_p1 || bus.pt_p2) begin
               // Saturating increment so the score can never wrap.
               if (bus.pt_p1) begin
                  n1          = (score_p1_q == '1) ? score_p1_q : score_p1_q + SCORE_W'(1);
                  serve_dir_d = 1'b0;
               end else begin
                  n2          = (score_p2_q == '1) ? score_p2_q : score_p2_q + SCORE_W'(1);
                  serve_dir_d = 1'b1;
               end
`ifdef PONG_WIN_BY_TWO_EN
               if ((n1 == n2) && ({1'b0, n1} >= WIN_EXT)) begin
                  n1 = SCORE_W'(WIN_SCORE - 1);
                  n2 = SCORE_W'(WIN_SCORE - 1);
               end
               p1_win = ({1'b0, n1} >= WIN_EXT) && ({1'b0, n1} >= {1'b0, n2} + (SCORE_W+1)'(2));
               p2_win = ({1'b0, n2} >= WIN_EXT) && ({1'b0, n2} >= {1'b0, n1} + (SCORE_W+1)'(2));
`else
               p1_win = ({1'b0, n1} == WIN_EXT);
               p2_win = ({1'b0, n2} == WIN_EXT);
`endif
               score_p1_d = n1;
               score_p2_d = n2;
               if (p1_win) begin
                  winner_d = 2'b01;
                  state_d  = OVER;
               end else if (p2_win) begin
                  winner_d = 2'b10;
                  state_d  = OVER;
               end else begin
                  state_d  = POINT;
               end
            end
         end
         POINT: begin
            // The button and the hold timeout both serve; either way only one transition.
            if (bus.sig_ctrl) begin
               state_d = SERVE;
            end else if (bus.frame) begin
               if (hold_cnt_q == HOLD_LAST) state_d = SERVE;
               else                         hold_cnt_d = hold_cnt_q + HOLD_W'(1);
            end
         end
         OVER: begin
            if (bus.sig_ctrl) begin
               state_d = IDLE;
            end else if (bus.frame) begin
               if (blink_cnt_q == BLINK_LAST) begin
                  blink_d     = ~blink_q;
                  blink_cnt_d = '0;
               end else begin
                  blink_cnt_d = blink_cnt_q + BLINK_W'(1);
               end
            end
         end
         default: state_d = IDLE;
      endcase

      if ((state_d == POINT) && (state_q != POINT)) hold_cnt_d = '0;
      if ((state_d == OVER) && (state_q != OVER)) begin
         blink_d     = 1'b1;
         blink_cnt_d = '0;
      end
      if (state_d != OVER) begin
         blink_d     = 1'b0;
         blink_cnt_d = '0;
      end
      // Entering or sitting in IDLE wipes the match.
      if (state_d == IDLE) begin
         score_p1_d  = '0;
         score_p2_d  = '0;
         serve_dir_d = 1'b0;
         winner_d    = 2'b00;
      end
   end

   assign bus.score_p1    = score_p1_q;
   assign bus.score_p2    = score_p2_q;
   assign bus.phase       = state_q;
   assign bus.rally       = rally_q;
   assign bus.serve_start = serve_start_q;
   assign bus.serve_dir   = serve_dir_q;
   assign bus.winner      = winner_q;
   assign bus.game_over   = game_over_q;
   assign bus.blink       = blink_q;
endmodule

// File: tb/tb_pong_match_ctrl.sv
// tb_pong_match_ctrl: directed bench for pong_match_ctrl with hand-computed expectations.
// Honours PONG_WIN_BY_TWO_EN for the final win-rule scenario.
module tb_pong_match_ctrl;
   localparam int SW = 4;

   logic clk_pix = 1'b0;
   logic rst     = 1'b1;
   int   vectors     = 0;
   int   miscompares = 0;

   pong_match_ctrl_if #(.SCORE_W(SW)) bus ();

   pong_match_ctrl #(
      .WIN_SCORE   (10),
      .SCORE_W     (SW),
      .HOLD_FRAMES (120),
      .BLINK_FRAMES(16)
   ) dut (
      .clk_pix(clk_pix),
      .rst    (rst),
      .bus    (bus)
   );

   always #5 clk_pix = ~clk_pix;

   initial begin
      #5_000_000;
      $display("FAIL watchdog: observed no finish, expected finish before time limit");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      vectors++;
      $display("check %-14s observed %0h expected %0h", tag, obs, exp);
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk_pix);
      #1;
   endtask

   task automatic ctrl();
      bus.sig_ctrl = 1'b1;
      step();
      bus.sig_ctrl = 1'b0;
   endtask

   task automatic frm();
      bus.frame = 1'b1;
      step();
      bus.frame = 1'b0;
   endtask

   task automatic pt(input logic a, input logic b);
      bus.pt_p1 = a;
      bus.pt_p2 = b;
      step();
      bus.pt_p1 = 1'b0;
      bus.pt_p2 = 1'b0;
   endtask

   // One full non-winning point from RALLY back to RALLY.
   task automatic point(input logic p1);
      pt(p1, ~p1);
      ctrl();
      ctrl();
   endtask

   initial begin
      bus.frame    = 1'b0;
      bus.sig_ctrl = 1'b0;
      bus.pt_p1    = 1'b0;
      bus.pt_p2    = 1'b0;

      // Reset state
      repeat (3) @(posedge clk_pix);
      #1;
      chk("rst_phase",  8'(bus.phase), 8'd0);
      chk("rst_s1",     8'(bus.score_p1), 8'd0);
      chk("rst_s2",     8'(bus.score_p2), 8'd0);
      chk("rst_rally",  8'(bus.rally), 8'd0);
      chk("rst_sstart", 8'(bus.serve_start), 8'd0);
      chk("rst_winner", 8'(bus.winner), 8'd0);
      chk("rst_over",   8'(bus.game_over), 8'd0);
      chk("rst_blink",  8'(bus.blink), 8'd0);
      rst = 1'b0;
      step();

      // IDLE -> SERVE -> RALLY
      ctrl();
      chk("serve_phase",  8'(bus.phase), 8'd1);
      chk("serve_start1", 8'(bus.serve_start), 8'd1);
      step();
      chk("serve_start0", 8'(bus.serve_start), 8'd0);
      ctrl();
      chk("rally_phase",  8'(bus.phase), 8'd2);
      chk("rally_hi",     8'(bus.rally), 8'd1);

      // Player 2 point, then auto-serve after 120 frames
      pt(1'b0, 1'b1);
      chk("p2pt_s2",    8'(bus.score_p2), 8'd1);
      chk("p2pt_dir",   8'(bus.serve_dir), 8'd1);
      chk("p2pt_phase", 8'(bus.phase), 8'd3);
      chk("p2pt_rally", 8'(bus.rally), 8'd0);
      repeat (119) begin
         frm();
         step();
      end
      chk("hold119",    8'(bus.phase), 8'd3);
      frm();
      chk("hold120",    8'(bus.phase), 8'd1);
      chk("hold_sstart", 8'(bus.serve_start), 8'd1);

      // Point pulses ignored in SERVE
      pt(1'b1, 1'b0);
      chk("serve_ign_s1", 8'(bus.score_p1), 8'd0);
      ctrl();

      // Simultaneous events: replay
      pt(1'b1, 1'b1);
      chk("both_phase", 8'(bus.phase), 8'd3);
      chk("both_s1",    8'(bus.score_p1), 8'd0);
      chk("both_s2",    8'(bus.score_p2), 8'd1);
      chk("both_dir",   8'(bus.serve_dir), 8'd1);
      bus.frame    = 1'b1;
      bus.sig_ctrl = 1'b1;
      step();
      bus.frame    = 1'b0;
      bus.sig_ctrl = 1'b0;
      chk("fc_phase",   8'(bus.phase), 8'd1);
      chk("fc_sstart",  8'(bus.serve_start), 8'd1);
      step();
      chk("fc_single",  8'(bus.serve_start), 8'd0);
      chk("fc_phase2",  8'(bus.phase), 8'd1);
      ctrl();

      // Build 5/4 and reset mid-rally
      repeat (5) point(1'b1);
      repeat (3) point(1'b0);
      chk("pre_rst_s1", 8'(bus.score_p1), 8'd5);
      chk("pre_rst_s2", 8'(bus.score_p2), 8'd4);
      @(negedge clk_pix);
      rst = 1'b1;
      #1;
      chk("arst_phase", 8'(bus.phase), 8'd0);
      chk("arst_rally", 8'(bus.rally), 8'd0);
      chk("arst_s1",    8'(bus.score_p1), 8'd0);
      chk("arst_s2",    8'(bus.score_p2), 8'd0);
      step();
      rst = 1'b0;
      pt(1'b1, 1'b0);
      chk("idle_ign_s1", 8'(bus.score_p1), 8'd0);
      chk("idle_phase",  8'(bus.phase), 8'd0);

      // 9/3 then winning point, blink, return to IDLE
      ctrl();
      ctrl();
      repeat (9) point(1'b1);
      repeat (3) point(1'b0);
      chk("pre_win_s1", 8'(bus.score_p1), 8'd9);
      pt(1'b1, 1'b0);
      chk("win_s1",     8'(bus.score_p1), 8'd10);
      chk("win_winner", 8'(bus.winner), 8'd1);
      chk("win_over",   8'(bus.game_over), 8'd1);
      chk("win_phase",  8'(bus.phase), 8'd4);
      chk("win_blink",  8'(bus.blink), 8'd1);
      chk("win_rally",  8'(bus.rally), 8'd0);
      repeat (15) frm();
      chk("blink15",    8'(bus.blink), 8'd1);
      frm();
      chk("blink16",    8'(bus.blink), 8'd0);
      repeat (16) frm();
      chk("blink32",    8'(bus.blink), 8'd1);
      pt(1'b0, 1'b1);
      chk("over_ign_s2", 8'(bus.score_p2), 8'd3);
      ctrl();
      chk("end_phase",  8'(bus.phase), 8'd0);
      chk("end_s1",     8'(bus.score_p1), 8'd0);
      chk("end_winner", 8'(bus.winner), 8'd0);
      chk("end_over",   8'(bus.game_over), 8'd0);
      chk("end_blink",  8'(bus.blink), 8'd0);

      // Win-rule scenario
      ctrl();
      ctrl();
`ifdef PONG_WIN_BY_TWO_EN
      repeat (9) point(1'b1);
      repeat (10) point(1'b0);
      chk("w2_s2_10",   8'(bus.score_p2), 8'd10);
      chk("w2_phase",   8'(bus.phase), 8'd2);
      pt(1'b1, 1'b0);
      chk("deuce_s1",   8'(bus.score_p1), 8'd9);
      chk("deuce_s2",   8'(bus.score_p2), 8'd9);
      chk("deuce_win",  8'(bus.winner), 8'd0);
      ctrl();
      ctrl();
      pt(1'b1, 1'b0);
      chk("adv_s1",     8'(bus.score_p1), 8'd10);
      chk("adv_phase",  8'(bus.phase), 8'd3);
      ctrl();
      ctrl();
      pt(1'b1, 1'b0);
      chk("w2_s1",      8'(bus.score_p1), 8'd11);
      chk("w2_winner",  8'(bus.winner), 8'd1);
      chk("w2_phase_o", 8'(bus.phase), 8'd4);
`else
      repeat (9) point(1'b1);
      repeat (9) point(1'b0);
      pt(1'b1, 1'b0);
      chk("w1_s1",      8'(bus.score_p1), 8'd10);
      chk("w1_s2",      8'(bus.score_p2), 8'd9);
      chk("w1_winner",  8'(bus.winner), 8'd1);
      chk("w1_phase",   8'(bus.phase), 8'd4);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
